// File: rtl/k052109_raster_scroll_gen.sv
// Raster H/V timing plus registered scroll sums (sx/sy lag the counters by one ce_pix).
// Optional screen flip of the sum operands is built with K052109_FLIP_EN defined.
module k052109_raster_scroll_gen #(
  parameter int H_TOTAL  = 384,
  parameter int H_ACTIVE = 288,
  parameter int HS_START = 304,
  parameter int HS_LEN   = 32,
  parameter int V_TOTAL  = 264,
  parameter int V_ACTIVE = 224,
  parameter int VS_START = 240,
  parameter int VS_LEN   = 8
) (
  input  logic       clk,
  input  logic       RES,
  input  logic       ce_pix,
  input  logic [8:0] scroll_x,
  input  logic [7:0] scroll_y,
  input  logic       flip,
  output logic [8:0] hcnt,
  output logic [8:0] vcnt,
  output logic       hblank,
  output logic       vblank,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [8:0] sx,
  output logic [7:0] sy
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_S   = 10'(HS_START);
  localparam logic [9:0] HS_E   = 10'(HS_START + HS_LEN);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_S   = 10'(VS_START);
  localparam logic [9:0] VS_E   = 10'(VS_START + VS_LEN);

  logic       h_wrap;
  logic       v_last;
  logic [8:0] hcnt_n;
  logic [8:0] vcnt_n;
  logic [8:0] shx;
  logic [7:0] shy;
  logic [8:0] hop;
  logic [7:0] vop;

  always_comb begin
    h_wrap = (hcnt == H_LAST);
    v_last = (vcnt == V_LAST);
    hcnt_n = h_wrap ? 9'd0 : hcnt + 9'd1;
    vcnt_n = vcnt;
    if (h_wrap) begin
      vcnt_n = v_last ? 9'd0 : vcnt + 9'd1;
    end
  end

`ifdef K052109_FLIP_EN
  logic shf;

  // Flip mirrors only the adder operands; raster outputs stay true.
  always_comb begin
    hop = shf ? ~hcnt : hcnt;
    vop = shf ? ~vcnt[7:0] : vcnt[7:0];
  end

  always_ff @(posedge clk or negedge RES) begin
    if (!RES) begin
      shf <= 1'b0;
    end else if (ce_pix && h_wrap) begin
      shf <= flip;
    end
  end
`else
  logic unused_flip;

  assign unused_flip = flip;

  always_comb begin
    hop = hcnt;
    vop = vcnt[7:0];
  end
`endif

  always_ff @(posedge clk or negedge RES) begin
    if (!RES) begin
      hcnt        <= 9'd0;
      vcnt        <= 9'd0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      sx          <= 9'd0;
      sy          <= 8'd0;
      shx         <= 9'd0;
      shy         <= 8'd0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce_pix) begin
        hcnt        <= hcnt_n;
        vcnt        <= vcnt_n;
        hblank      <= ({1'b0, hcnt_n} >= H_ACT);
        vblank      <= ({1'b0, vcnt_n} >= V_ACT);
        hsync       <= ({1'b0, hcnt_n} >= HS_S) && ({1'b0, hcnt_n} < HS_E);
        vsync       <= ({1'b0, vcnt_n} >= VS_S) && ({1'b0, vcnt_n} < VS_E);
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_last;
        // Sums use the pre-increment counters and the shadow of the current line.
        sx          <= hop + shx;
        sy          <= vop + shy;
        if (h_wrap) begin
          shx <= scroll_x;
          shy <= scroll_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_k052109_raster_scroll_gen.sv
// Bench for k052109_raster_scroll_gen: full-size and shrunken raster instances against a pixel-count model.
module tb_k052109_raster_scroll_gen;

  logic       clk = 1'b0;
  logic       RES;
  logic       ce_pix;
  logic [8:0] scroll_x;
  logic [7:0] scroll_y;
  logic       flip;

  logic [8:0] hcnt_b, vcnt_b, sx_b, hcnt_s, vcnt_s, sx_s;
  logic [7:0] sy_b, sy_s;
  logic hblank_b, vblank_b, hsync_b, vsync_b, ls_b, fs_b;
  logic hblank_s, vblank_s, hsync_s, vsync_s, ls_s, fs_s;

  int vectors = 0;
  int errors  = 0;
  int ls_cnt_b = 0, fs_cnt_b = 0, fs_cnt_s = 0;

`ifdef K052109_FLIP_EN
  localparam bit FLIP_ON = 1'b1;
`else
  localparam bit FLIP_ON = 1'b0;
`endif

  // Raster geometry of instance 0 (full size) and instance 1 (shrunken for whole-frame coverage)
  int HT[2]  = '{384, 24};
  int HA[2]  = '{288, 18};
  int HSS[2] = '{304, 19};
  int HSL[2] = '{32, 3};
  int VT[2]  = '{264, 12};
  int VA[2]  = '{224, 9};
  int VSS[2] = '{240, 10};
  int VSL[2] = '{8, 1};

  always #5 clk = ~clk;

  k052109_raster_scroll_gen dut (
    .clk(clk), .RES(RES), .ce_pix(ce_pix), .scroll_x(scroll_x), .scroll_y(scroll_y), .flip(flip),
    .hcnt(hcnt_b), .vcnt(vcnt_b), .hblank(hblank_b), .vblank(vblank_b), .hsync(hsync_b),
    .vsync(vsync_b), .line_start(ls_b), .frame_start(fs_b), .sx(sx_b), .sy(sy_b)
  );

  k052109_raster_scroll_gen #(
    .H_TOTAL(24), .H_ACTIVE(18), .HS_START(19), .HS_LEN(3),
    .V_TOTAL(12), .V_ACTIVE(9), .VS_START(10), .VS_LEN(1)
  ) dut_s (
    .clk(clk), .RES(RES), .ce_pix(ce_pix), .scroll_x(scroll_x), .scroll_y(scroll_y), .flip(flip),
    .hcnt(hcnt_s), .vcnt(vcnt_s), .hblank(hblank_s), .vblank(vblank_s), .hsync(hsync_s),
    .vsync(vsync_s), .line_start(ls_s), .frame_start(fs_s), .sx(sx_s), .sy(sy_s)
  );

  logic [40:0] vec_b, vec_s;
  assign vec_b = {hcnt_b, vcnt_b, hblank_b, vblank_b, hsync_b, vsync_b, ls_b, fs_b, sx_b, sy_b};
  assign vec_s = {hcnt_s, vcnt_s, hblank_s, vblank_s, hsync_s, vsync_s, ls_s, fs_s, sx_s, sy_s};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Model: position is just the number of pixels since reset; each line uses the
  // scroll/flip values present when that line began (zero for the first line).
  int          pix[2];
  logic [8:0]  m_shx[2];
  logic [7:0]  m_shy[2];
  logic        m_shf[2];
  logic [40:0] expv[2];

  always begin
    int h, v, nh, nv, ox, oy;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!RES) begin
        pix[k] = 0; m_shx[k] = '0; m_shy[k] = '0; m_shf[k] = 1'b0; expv[k] = '0;
      end else if (ce_pix) begin
        h  = pix[k] % HT[k];
        v  = (pix[k] / HT[k]) % VT[k];
        ox = (FLIP_ON && m_shf[k]) ? 511 - h : h;
        oy = (FLIP_ON && m_shf[k]) ? 255 - (v % 256) : v % 256;
        pix[k]++;
        nh = pix[k] % HT[k];
        nv = (pix[k] / HT[k]) % VT[k];
        expv[k] = {9'(nh), 9'(nv), nh >= HA[k], nv >= VA[k],
                   (nh >= HSS[k]) && (nh < HSS[k] + HSL[k]),
                   (nv >= VSS[k]) && (nv < VSS[k] + VSL[k]),
                   nh == 0, (nh == 0) && (nv == 0),
                   9'((ox + int'(m_shx[k])) % 512), 8'((oy + int'(m_shy[k])) % 256)};
        if (nh == 0) begin
          m_shx[k] = scroll_x; m_shy[k] = scroll_y; m_shf[k] = flip;
        end
      end else begin
        expv[k][18:17] = 2'b00;
      end
    end
    #1;
    chk("big_outputs", 64'(vec_b), 64'(expv[0]));
    chk("small_outputs", 64'(vec_s), 64'(expv[1]));
    ls_cnt_b += int'(ls_b);
    fs_cnt_b += int'(fs_b);
    fs_cnt_s += int'(fs_s);
  end

  task automatic cyc(input logic c);
    ce_pix = c;
    @(posedge clk);
    #2;
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!((int'(hcnt_b) == h) && (v < 0 || int'(vcnt_b) == v)) && n < 50000) begin
      cyc(1'b1);
      n++;
    end
    chk("run_to_budget", 64'(n < 50000), 64'd1);
  endtask

  initial begin
    RES = 1'b1; ce_pix = 1'b0; scroll_x = '0; scroll_y = '0; flip = 1'b0;
    #3 RES = 1'b0;
    repeat (3) cyc(1'b1);
    chk("reset_big", 64'(vec_b), 64'd0);
    chk("reset_small", 64'(vec_s), 64'd0);
    RES = 1'b1;
    ls_cnt_b = 0; fs_cnt_b = 0; fs_cnt_s = 0;
    repeat (3) cyc(1'b0);
    chk("held_after_release", 64'(vec_b), 64'd0);

    // One full line at one pixel per clk
    for (int i = 0; i < 384; i++) begin
      cyc(1'b1);
      if (hcnt_b == 9'd287) chk("hblank_287", 64'(hblank_b), 64'd0);
      if (hcnt_b == 9'd288) chk("hblank_288", 64'(hblank_b), 64'd1);
      if (hcnt_b == 9'd303) chk("hsync_303", 64'(hsync_b), 64'd0);
      if (hcnt_b == 9'd304) chk("hsync_304", 64'(hsync_b), 64'd1);
      if (hcnt_b == 9'd335) chk("hsync_335", 64'(hsync_b), 64'd1);
      if (hcnt_b == 9'd336) chk("hsync_336", 64'(hsync_b), 64'd0);
    end
    chk("line_hcnt", 64'(hcnt_b), 64'd0);
    chk("line_vcnt", 64'(vcnt_b), 64'd1);
    chk("line_start_count", 64'(ls_cnt_b), 64'd1);
    chk("frame_start_big", 64'(fs_cnt_b), 64'd0);
    chk("frame_start_small", 64'(fs_cnt_s), 64'd1);
    chk("small_vcnt", 64'(vcnt_s), 64'd4);

    // Half-rate pixel enable with scroll churn
    for (int i = 0; i < 800; i++) begin
      scroll_x = 9'($urandom); scroll_y = 8'($urandom); flip = 1'($urandom);
      cyc(1'((i % 2) == 0));
    end
    // Random pixel enable
    for (int i = 0; i < 2000; i++) begin
      scroll_x = 9'($urandom); scroll_y = 8'($urandom); flip = 1'($urandom);
      cyc(1'($urandom_range(0, 3) != 0));
    end

    // Mid-line scroll change takes effect on the next line only
    scroll_x = '0; scroll_y = '0; flip = 1'b0;
    cyc(1'b1);
    run_to(0, -1);
    run_to(100, -1);
    scroll_x = 9'h1F0;
    run_to(200, -1);
    cyc(1'b1);
    chk("sx_same_line", 64'(sx_b), 64'd200);
    run_to(0, -1);
    cyc(1'b1);
    chk("sx_next_line", 64'(sx_b), 64'h1F0);
    run_to(32, -1);
    cyc(1'b1);
    chk("sx_wrap", 64'(sx_b), 64'h010);

    // Y sum wraps mod 256; flip mirrors the operands when built in
    RES = 1'b0;
    cyc(1'b0);
    RES = 1'b1;
    scroll_x = '0; scroll_y = 8'hFF; flip = 1'b1;
    run_to(0, 5);
    cyc(1'b1);
    chk("sy_wrap", 64'(sy_b), FLIP_ON ? 64'hF9 : 64'h04);
    chk("sx_flip", 64'(sx_b), FLIP_ON ? 64'h1FF : 64'h000);

    // Asynchronous abort mid-frame and clean restart
    flip = 1'b0;
    run_to(150, 100);
    RES = 1'b0;
    #1;
    chk("async_reset_big", 64'(vec_b), 64'd0);
    chk("async_reset_small", 64'(vec_s), 64'd0);
    cyc(1'b1);
    cyc(1'b1);
    RES = 1'b1;
    chk("restart_hcnt", 64'(hcnt_b), 64'd0);
    cyc(1'b1);
    chk("restart_first_pixel", 64'({hcnt_b, vcnt_b}), 64'({9'd1, 9'd0}));
    cyc(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
